// File: rtl/sync_ram_dp_uram_piped.sv
// True dual-port UltraRAM-style RAM: every input of both ports is retimed through
// NUM_STAGES reset-cleared flops, and read data comes back in no-change mode from a registered output.
module sync_ram_dp_uram_piped #(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 64,
    parameter int DEPTH      = 4096,
    parameter int NUM_STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] d0,
    input  logic              en0,
    input  logic              we0,
    output logic [DWIDTH-1:0] q0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] d1,
    input  logic              en1,
    input  logic              we1,
    output logic [DWIDTH-1:0] q1
);
    localparam int PW = AWIDTH + DWIDTH + 2;
    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH + 1)'(DEPTH);

    logic [PW-1:0] in0, in1, p0, p1;
    logic [AWIDTH-1:0] addr0_p, addr1_p;
    logic [DWIDTH-1:0] d0_p, d1_p;
    logic en0_p, we0_p, en1_p, we1_p;
    logic in_range0, in_range1, wr0, wr1;

    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    assign in0 = {en0, we0, addr0, d0};
    assign in1 = {en1, we1, addr1, d1};

    generate
        if (NUM_STAGES == 0) begin : g_pass
            assign p0 = in0;
            assign p1 = in1;
        end else begin : g_pipe
            logic [PW-1:0] s0 [NUM_STAGES];
            logic [PW-1:0] s1 [NUM_STAGES];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        s0[i] <= '0;
                        s1[i] <= '0;
                    end
                end else begin
                    s0[0] <= in0;
                    s1[0] <= in1;
                    for (int i = 1; i < NUM_STAGES; i++) begin
                        s0[i] <= s0[i-1];
                        s1[i] <= s1[i-1];
                    end
                end
            end

            assign p0 = s0[NUM_STAGES-1];
            assign p1 = s1[NUM_STAGES-1];
        end
    endgenerate

    assign {en0_p, we0_p, addr0_p, d0_p} = p0;
    assign {en1_p, we1_p, addr1_p, d1_p} = p1;

    assign in_range0 = {1'b0, addr0_p} < DEPTH_L;
    assign in_range1 = {1'b0, addr1_p} < DEPTH_L;

    // Gating with rst keeps a passthrough (NUM_STAGES=0) write from landing during reset.
    assign wr0 = rst & en0_p & we0_p & in_range0;
    assign wr1 = rst & en1_p & we1_p & in_range1;

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (wr0) mem[addr0_p[MAW-1:0]] <= d0_p;
        if (wr1) mem[addr1_p[MAW-1:0]] <= d1_p;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0 <= '0;
        end else if (en0_p && !we0_p) begin
            q0 <= in_range0 ? mem[addr0_p[MAW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1 <= '0;
        end else if (en1_p && !we1_p) begin
            q1 <= in_range1 ? mem[addr1_p[MAW-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_sync_ram_dp_uram_piped.sv
// Bench for sync_ram_dp_uram_piped: four instances (stages 1/0/3, and a 2048-deep one)
// share stimulus; a per-instance array/delay-line model plus constant vectors check them.
module tb_sync_ram_dp_uram_piped;
    localparam int NI = 4;
    localparam int STG [NI] = '{1, 0, 3, 1};
    localparam int DEP [NI] = '{4096, 4096, 4096, 2048};
    localparam logic [63:0] DB = 64'hDEADBEEF_00000001;
    localparam logic [63:0] BIG = 64'h01234567_89ABCDEF;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [11:0] a;
        logic [63:0] d;
    } req_t;

    typedef struct packed {
        req_t        r0;
        req_t        r1;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    req_t drv [2];
    logic [NI*2-1:0][63:0] qa;

    logic [63:0] mm [NI][4096];
    bit          mk [NI][4096];
    logic [63:0] eq [NI][2];
    bit          ek [NI][2];
    req_t        dl [NI][2][3];
    int n_chk = 0;
    int n_pass = 0;
    vec_t tbl [19];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sync_ram_dp_uram_piped #(
            .AWIDTH(12), .DWIDTH(64), .DEPTH(DEP[g]), .NUM_STAGES(STG[g])
        ) u_dut (
            .clk(clk), .rst(rst),
            .addr0(drv[0].a), .d0(drv[0].d), .en0(drv[0].en), .we0(drv[0].we), .q0(qa[2*g]),
            .addr1(drv[1].a), .d1(drv[1].d), .en1(drv[1].en), .we1(drv[1].we), .q1(qa[2*g+1])
        );
    end

    function automatic req_t mk_req(logic en, logic we, logic [11:0] a, logic [63:0] d);
        req_t r;
        r.en = en;
        r.we = we;
        r.a  = a;
        r.d  = d;
        return r;
    endfunction

    function automatic req_t W(logic [11:0] a, logic [63:0] d);
        return mk_req(1'b1, 1'b1, a, d);
    endfunction

    function automatic req_t R(logic [11:0] a);
        return mk_req(1'b1, 1'b0, a, 64'h0);
    endfunction

    function automatic req_t I();
        return mk_req(1'b0, 1'b0, 12'h0, 64'h0);
    endfunction

    function automatic vec_t V(req_t a, req_t b, logic [63:0] e0, logic [63:0] e1);
        vec_t v;
        v.r0 = a;
        v.r1 = b;
        v.e0 = e0;
        v.e1 = e1;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++)
            for (int p = 0; p < 2; p++) begin
                eq[i][p] = 64'h0;
                ek[i][p] = 1'b1;
                for (int k = 0; k < 3; k++) dl[i][p][k] = '0;
            end
    endtask

    // Spec rules: request reaches the array STG edges late; reads see pre-edge contents;
    // port 1 write applied last; out-of-range writes dropped, reads give 0.
    task automatic model_step();
        req_t r [2];
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (STG[i] == 0) begin
                    r[p] = drv[p];
                end else begin
                    r[p] = dl[i][p][STG[i]-1];
                    for (int k = STG[i] - 1; k > 0; k--) dl[i][p][k] = dl[i][p][k-1];
                    dl[i][p][0] = drv[p];
                end
            end
            for (int p = 0; p < 2; p++)
                if (r[p].en && !r[p].we) begin
                    if (int'(r[p].a) >= DEP[i]) begin
                        eq[i][p] = 64'h0;
                        ek[i][p] = 1'b1;
                    end else begin
                        eq[i][p] = mm[i][r[p].a];
                        ek[i][p] = mk[i][r[p].a];
                    end
                end
            for (int p = 0; p < 2; p++)
                if (r[p].en && r[p].we && int'(r[p].a) < DEP[i]) begin
                    mm[i][r[p].a] = r[p].d;
                    mk[i][r[p].a] = 1'b1;
                end
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < NI; i++)
            for (int p = 0; p < 2; p++)
                if (ek[i][p]) chk($sformatf("model inst%0d q%0d", i, p), qa[2*i+p], eq[i][p]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic put(req_t a, req_t b);
        drv[0] = a;
        drv[1] = b;
    endtask

    function automatic logic [11:0] raddr();
        int k;
        k = $urandom_range(0, 11);
        case (k)
            8:       return 12'h7FF;
            9:       return 12'h800;
            10:      return 12'hFFF;
            11:      return 12'h100;
            default: return 12'(k);
        endcase
    endfunction

    function automatic req_t rreq();
        return mk_req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), raddr(),
                      {$urandom, $urandom});
    endfunction

    initial begin
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 4096; a++) begin
                mm[i][a] = 64'h0;
                mk[i][a] = 1'b0;
            end
        model_reset();
        rst = 1'b0;
        put(I(), I());

        tbl[0]  = V(W(12'h005, DB), I(), 64'h0, 64'h0);
        tbl[1]  = V(I(), R(12'h005), 64'h0, 64'h0);
        tbl[2]  = V(I(), I(), 64'h0, DB);
        tbl[3]  = V(W(12'h000, 64'h00), I(), 64'h0, DB);
        tbl[4]  = V(W(12'h001, 64'h11), I(), 64'h0, DB);
        tbl[5]  = V(W(12'h002, 64'h22), I(), 64'h0, DB);
        tbl[6]  = V(W(12'h003, 64'h33), I(), 64'h0, DB);
        tbl[7]  = V(R(12'h000), I(), 64'h0, DB);
        tbl[8]  = V(R(12'h001), I(), 64'h00, DB);
        tbl[9]  = V(R(12'h002), I(), 64'h11, DB);
        tbl[10] = V(R(12'h003), I(), 64'h22, DB);
        tbl[11] = V(W(12'h100, 64'hAA), W(12'h100, 64'hBB), 64'h33, DB);
        tbl[12] = V(W(12'h100, 64'hCC), R(12'h100), 64'h33, DB);
        tbl[13] = V(R(12'h100), I(), 64'h33, 64'hBB);
        tbl[14] = V(W(12'hFFF, BIG), I(), 64'hCC, 64'hBB);
        tbl[15] = V(I(), R(12'hFFF), 64'hCC, 64'hBB);
        tbl[16] = V(R(12'h002), R(12'h002), 64'hCC, BIG);
        tbl[17] = V(I(), I(), 64'h22, 64'h22);
        tbl[18] = V(I(), I(), 64'h22, 64'h22);

        step();
        step();
        rst = 1'b1;
        step();
        step();
        chk("idle after reset q0", qa[0], 64'h0);
        chk("idle after reset q1", qa[1], 64'h0);

        for (int n = 0; n < 19; n++) begin
            put(tbl[n].r0, tbl[n].r1);
            step();
            chk($sformatf("tbl row%0d q0", n), qa[0], tbl[n].e0);
            chk($sformatf("tbl row%0d q1", n), qa[1], tbl[n].e1);
        end

        // DEPTH=2048 instance: 0x800 is out of range and must not alias onto 0x000.
        put(W(12'h800, 64'h55), I());
        step();
        put(I(), R(12'h800));
        step();
        put(I(), R(12'h003));
        step();
        chk("d2048 oob read q1", qa[7], 64'h0);
        chk("d4096 0x800 read q1", qa[1], 64'h55);
        put(I(), R(12'h000));
        step();
        chk("d2048 read 0x003", qa[7], 64'h33);
        put(I(), I());
        step();
        chk("d2048 no alias 0x000", qa[7], 64'h00);

        // Reset lands one cycle after a write to 0x005 is presented.
        put(W(12'h005, 64'h77), I());
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        model_check();
        chk("async reset q0", qa[0], 64'h0);
        chk("async reset q1", qa[1], 64'h0);
        put(I(), I());
        step();
        rst = 1'b1;
        step();
        step();
        chk("post-release idle q0", qa[0], 64'h0);
        chk("post-release idle q1", qa[1], 64'h0);
        put(R(12'h005), I());
        step();
        put(I(), I());
        step();
        chk("dropped write old data", qa[0], DB);
        for (int n = 0; n < 4; n++) step();
        chk("stages0 write before reset", qa[2], 64'h77);
        chk("stages3 write dropped", qa[4], DB);

        // Latency sweep: 1 edge for stages=0, 4 edges for stages=3.
        put(R(12'h001), I());
        for (int n = 1; n <= 5; n++) begin
            step();
            put(I(), I());
            chk($sformatf("stages0 lat edge%0d", n), qa[2], 64'h11);
            chk($sformatf("stages3 lat edge%0d", n), qa[4], (n >= 4) ? 64'h11 : DB);
        end

        for (int n = 0; n < 400; n++) begin
            put(rreq(), rreq());
            step();
        end
        put(I(), I());
        for (int n = 0; n < 5; n++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
